// File: rtl/demux_router.sv
// Routes each beat to one of NUM_OUT lanes through a 2-entry in-order buffer, 1-cycle latency.
// Backpressure: in_ready is registered and drops once two beats are held; a stalled head blocks later beats.
module demux_router #(
    parameter int WIDTH   = 8,
    parameter int NUM_OUT = 31
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [4:0]         in_sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic               drop,
    output logic [7:0]         drop_cnt,
    output logic [15:0]        xfer_cnt
);

    typedef struct packed {
        logic [WIDTH-1:0] dat;
        logic [4:0]       sel;
    } entry_t;

    entry_t      ent0_q, ent0_d;
    entry_t      ent1_q, ent1_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        in_ready_q, in_ready_d;
    logic        drop_q, drop_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic [15:0] xfer_cnt_q, xfer_cnt_d;

    logic accept;
    logic sel_bad;
    logic push;
    logic pop;

    always_comb begin
        accept    = in_valid & in_ready_q;
        sel_bad   = 32'(in_sel) >= NUM_OUT;
        push      = accept & ~sel_bad;
        out_valid = (cnt_q != 2'd0) ? (NUM_OUT'(1) << ent0_q.sel) : '0;
        pop       = |(out_valid & out_ready);
    end

    always_comb begin
        cnt_d      = cnt_q;
        ent0_d     = ent0_q;
        ent1_d     = ent1_q;
        drop_d     = accept & sel_bad;
        drop_cnt_d = drop_cnt_q;
        xfer_cnt_d = xfer_cnt_q;

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        if (pop && cnt_q == 2'd2) begin
            ent0_d = ent1_q;
        end
        // A push lands behind the surviving head, or becomes the head if none survives.
        if (push) begin
            if (cnt_q == 2'd1 && !pop) begin
                ent1_d = '{dat: in_data, sel: in_sel};
            end else begin
                ent0_d = '{dat: in_data, sel: in_sel};
            end
        end

        if (drop_d && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
        if (pop) begin
            xfer_cnt_d = xfer_cnt_q + 16'd1;
        end

        in_ready_d = (cnt_d < 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q     <= '0;
            ent1_q     <= '0;
            cnt_q      <= 2'd0;
            in_ready_q <= 1'b0;
            drop_q     <= 1'b0;
            drop_cnt_q <= 8'd0;
            xfer_cnt_q <= 16'd0;
        end else begin
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign in_ready = in_ready_q;
    assign out_data = ent0_q.dat;
    assign drop     = drop_q;
    assign drop_cnt = drop_cnt_q;
    assign xfer_cnt = xfer_cnt_q;

endmodule
